// File: rtl/matmul_pkg.sv
// Shared types and helpers for the sequential N x N matrix multiplier.
package matmul_pkg;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_COMP = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    // Index width for a range of v values, never narrower than one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/matmul_mac.sv
// Registered W x W multiply-accumulate; the 2W accumulator wraps silently.
module matmul_mac #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           en,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] acc
);

    logic [2*W-1:0] prod;

    assign prod = (2*W)'(a) * (2*W)'(b);

    // clr wins over en so a new element always starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + prod;
        end
    end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Streams A and B in, steps i/j/k through one MAC, and streams C out row-major.
// Handshakes: a beat moves on a rising edge where valid && ready; valid holds its data until then.
module matmul_seq_ctrl
    import matmul_pkg::*;
#(
    parameter int N = 3,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_data,
    output logic           out_last,
    output logic           busy,
    output logic [1:0]     fsm_state
);

    localparam int NN    = N * N;
    localparam int DEPTH = 2 * NN;
    localparam int IDX_W = clog2_min1(N);
    localparam int LD_W  = clog2_min1(DEPTH);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic [LD_W-1:0]  LD_LAST  = LD_W'(DEPTH - 1);

    state_t state, state_nxt;

    logic [LD_W-1:0]  ld_cnt;
    logic [IDX_W-1:0] i_cnt, j_cnt, k_cnt;
    logic [W-1:0]     mem [DEPTH];
    logic [LD_W-1:0]  a_addr, b_addr;
    logic [W-1:0]     a_op, b_op;
    logic [2*W-1:0]   acc, prod, sum;
    logic             load_hs, load_done, out_hs, k_last;

    assign load_hs   = in_valid && in_ready;
    assign load_done = load_hs && (ld_cnt == LD_LAST);
    assign out_hs    = out_valid && out_ready;
    assign k_last    = (k_cnt == IDX_LAST);

    // A occupies the first N*N words, B the next N*N, both row-major.
    assign a_addr = LD_W'(int'(i_cnt) * N + int'(k_cnt));
    assign b_addr = LD_W'(NN + int'(k_cnt) * N + int'(j_cnt));
    assign a_op   = mem[a_addr];
    assign b_op   = mem[b_addr];
    assign prod   = (2*W)'(a_op) * (2*W)'(b_op);
    assign sum    = acc + prod;

    // Operand storage is deliberately unreset; every job rewrites all of it.
    always_ff @(posedge clk) begin
        if (load_hs && rst_n) begin
            mem[ld_cnt] <= in_data;
        end
    end

    matmul_mac #(.W(W)) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (load_done || out_hs),
        .en    (state == S_COMP),
        .a     (a_op),
        .b     (b_op),
        .acc   (acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD: if (load_done) state_nxt = S_COMP;
            S_COMP: if (k_last) state_nxt = S_OUT;
            S_OUT:  if (out_hs) state_nxt = out_last ? S_LOAD : S_COMP;
            default: state_nxt = S_LOAD;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b1;
        fsm_state = state;
        if (state == S_LOAD) begin
            in_ready = 1'b1;
            busy     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_cnt    <= '0;
            i_cnt     <= '0;
            j_cnt     <= '0;
            k_cnt     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (load_hs) begin
                        ld_cnt <= (ld_cnt == LD_LAST) ? '0 : ld_cnt + LD_W'(1);
                    end
                    if (load_done) begin
                        i_cnt <= '0;
                        j_cnt <= '0;
                        k_cnt <= '0;
                    end
                end
                S_COMP: begin
                    k_cnt <= k_last ? '0 : k_cnt + IDX_W'(1);
                    if (k_last) begin
                        out_data  <= sum;
                        out_valid <= 1'b1;
                        out_last  <= (i_cnt == IDX_LAST) && (j_cnt == IDX_LAST);
                    end
                end
                S_OUT: begin
                    if (out_hs) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (out_last) begin
                            i_cnt  <= '0;
                            j_cnt  <= '0;
                            ld_cnt <= '0;
                        end else if (j_cnt == IDX_LAST) begin
                            j_cnt <= '0;
                            i_cnt <= i_cnt + IDX_W'(1);
                        end else begin
                            j_cnt <= j_cnt + IDX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed bench for matmul_seq_ctrl (N=3, W=8): table of jobs plus stall, throughput and reset sequences.
module tb_matmul_seq_ctrl;

    localparam int N  = 3;
    localparam int W  = 8;
    localparam int NN = N * N;

    typedef struct packed {
        logic [NN-1:0][W-1:0]   a;
        logic [NN-1:0][W-1:0]   b;
        logic [NN-1:0][2*W-1:0] c;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_data = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] out_data;
    logic           out_last;
    logic           busy;
    logic [1:0]     fsm_state;

    matmul_seq_ctrl #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int n_out = 0;
    int last_load_cyc = 0;
    int first_valid_cyc = 0;
    int last_hs_cyc = 0;
    bit first_seen = 1'b1;

    logic [2*W:0] exp_q[$];
    vec_t vecs[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [2*W:0] e;
        if (rst_n && out_valid && !first_seen) begin
            first_seen = 1'b1;
            first_valid_cyc = cyc;
        end
        if (rst_n && out_valid && out_ready) begin
            n_out++;
            last_hs_cyc = cyc + 1;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out actual=%0d required=none", out_data);
            end else begin
                e = exp_q.pop_front();
                check("out_data", 32'(out_data), 32'(e[2*W-1:0]));
                check("out_last", 32'(out_last), 32'(e[2*W]));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic push_exp(input vec_t v);
        for (int e = 0; e < NN; e++) exp_q.push_back({(e == NN - 1), v.c[e]});
    endtask

    task automatic load_job(input vec_t v, input bit gaps);
        int t;
        for (int b = 0; b < 2 * NN; b++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) step();
            end
            in_valid = 1'b1;
            in_data = (b < NN) ? v.a[b] : v.b[b - NN];
            t = 0;
            while (!in_ready && t < 50) begin
                step();
                t++;
            end
            if (t >= 50) check("load_ready_timeout", 32'(in_ready), 32'd1);
            step();
        end
        in_valid = 1'b0;
        last_load_cyc = cyc;
    endtask

    task automatic drain_ready();
        int t = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && t < 200) begin
            step();
            t++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout_left", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        check("next_job_in_ready", 32'(in_ready), 32'd1);
        check("next_job_busy", 32'(busy), 32'd0);
    endtask

    // out_ready low except a one-cycle pulse per element; stray in_valid during compute.
    task automatic drain_stall(input vec_t v);
        int t;
        out_ready = 1'b0;
        for (int e = 0; e < NN; e++) begin
            t = 0;
            while (!out_valid && t < 50) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data = 8'($urandom);
                step();
                t++;
            end
            in_valid = 1'b0;
            if (t >= 50) check("stall_valid_timeout", 32'(out_valid), 32'd1);
            if (e == 3) begin
                repeat (10) begin
                    check("hold_data", 32'(out_data), 32'(v.c[3]));
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_in_ready", 32'(in_ready), 32'd0);
                    step();
                end
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        check("stall_end_in_ready", 32'(in_ready), 32'd1);
        check("stall_end_queue", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        failures++;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int exp1[NN] = '{30, 36, 42, 66, 81, 96, 102, 126, 150};
        int t;
        int base;

        for (int e = 0; e < NN; e++) begin
            vecs[0].a[e] = (e % 4 == 0) ? 8'd1 : 8'd0;
            vecs[0].b[e] = 8'(e + 1);
            vecs[0].c[e] = 16'(e + 1);
            vecs[1].a[e] = 8'(e + 1);
            vecs[1].b[e] = 8'(e + 1);
            vecs[1].c[e] = 16'(exp1[e]);
            vecs[2].a[e] = 8'd255;
            vecs[2].b[e] = 8'd255;
            vecs[2].c[e] = 16'd64003;
        end

        repeat (3) step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_state", 32'(fsm_state), 32'd0);
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 3; v++) begin
            push_exp(vecs[v]);
            load_job(vecs[v], v == 1);
            first_seen = 1'b0;
            if (v == 1) begin
                drain_stall(vecs[v]);
            end else begin
                drain_ready();
                check("latency_edges", 32'(first_valid_cyc - last_load_cyc), 32'd3);
                check("job_cycles", 32'(last_hs_cyc - last_load_cyc), 32'd36);
            end
        end

        // Reset in the middle of the output stream.
        push_exp(vecs[1]);
        load_job(vecs[1], 1'b0);
        base = n_out;
        out_ready = 1'b1;
        t = 0;
        while (n_out < base + 5 && t < 200) begin
            step();
            t++;
        end
        t = 0;
        while (!out_valid && t < 50) begin
            step();
            t++;
        end
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_last", 32'(out_last), 32'd0);
        exp_q.delete();
        in_valid = 1'b1;
        in_data = 8'hAA;
        repeat (2) step();
        in_valid = 1'b0;
        rst_n = 1'b1;
        step();

        push_exp(vecs[0]);
        load_job(vecs[0], 1'b1);
        drain_ready();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
